uart_rxd: RTL
=============

UART_RXD -- requirements
Module: uart_rxd

Interface
REQ-001 SHALL have parameter CLK_DIV, default 208: clk cycles per bit (24 MHz / 115200); legal range 8..4095.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port rxd  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-005 SHALL have port rd  input  1  single-cycle read strobe from host port logic; acknowledges the current byte.
REQ-006 SHALL have port data  output  8  last correctly framed byte.
REQ-007 SHALL have port ready  output  1  unread byte present in data.
REQ-008 SHALL have port overrun  output  1  a byte arrived while ready was set and not being read.
REQ-009 SHALL have port ferr  output  1  framing error: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  receiver in any state other than IDLE.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-012 SHALL run a state machine with states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on rxs 1->0 (edge-detect register), load bit counter with HALF-1 (HALF=CLK_DIV/2, integer), go to START.
REQ-014 Bit counter SHALL decrement every clk; a sample event occurs on the cycle the counter is 0, and the counter then reloads with CLK_DIV-1.
REQ-015 START: at sample, rxs=1 -> glitch, return to IDLE with no flag change; rxs=0 -> clear bit index, go to DATA.
REQ-016 DATA: at each sample, shift rxs into shift[7] (shift right); after the 8th sample (bit index 7) go to STOP.
REQ-017 STOP: at sample, rxs=1 -> data<=shift, ready<=1, go to IDLE; rxs=0 -> ferr<=1, data unchanged, go to BREAK.
REQ-018 BREAK: stay until rxs=1, then IDLE; no start edge is accepted while in BREAK.
REQ-019 The stop sample SHALL occur exactly HALF+9*CLK_DIV cycles after the falling-edge detect cycle; ready/data update on the following edge.
REQ-020 overrun SHALL set when a good byte completes while ready=1 and rd=0; the new byte overwrites data.
REQ-021 rd=1 SHALL clear ready, overrun and ferr on the next edge.
REQ-022 Simultaneous rd and good-byte completion: byte wins; ready stays 1, data takes new byte, overrun not set, ferr cleared.
REQ-023 Simultaneous rd and framing error: ferr=1, ready cleared.
REQ-024 rd while ready=0 SHALL have no effect other than clearing flags; it never disturbs reception in progress.
REQ-025 busy SHALL be combinational decode of state != IDLE.

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE, synchronizer flops and edge register 1, counter 0, bit index 0, shift 0, data 8'h00, ready 0, overrun 0, ferr 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, the remainder of that frame is not decoded until a fresh 1->0 edge follows a high level.

Structure
REQ-028 State encoding constants and default CLK_DIV SHALL live in a shared include file used by uart_rxd and the existing transmitter.
REQ-029 The 2-flop synchronizer plus edge detect SHALL be a sub-module named rx_sync (ports clk, reset_n, d, q, fall).
REQ-030 Target size 120-250 lines RTL; no memories, no FIFO.

Verification (bench uses CLK_DIV=16, HALF=8)
REQ-031 Send 0xA5 8N1 -> ready=1, data=8'hA5 exactly 8+9*16+1 cycles after edge detect, ferr=0, overrun=0.
REQ-032 Send 0x3C, no rd, then 0x5A -> data=8'h5A, ready=1, overrun=1; rd -> ready=0, overrun=0.
REQ-033 Low pulse of 4 cycles on idle line -> back to IDLE, ready=0, ferr=0, busy high only ~10 cycles.
REQ-034 Frame 0xFF with stop bit low, line held low 40 cycles -> ferr=1, data unchanged, busy=1 until line high, then 0x12 received correctly.
REQ-035 rd asserted on the same cycle as 0x77 completion with ready=1 -> data=8'h77, ready=1, overrun=0.
REQ-036 reset_n pulsed low at DATA bit 4 of 0xC3 -> all outputs zero immediately; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rxd_pkg.sv
// uart_rxd_pkg: UART receiver state encoding and default bit period
package uart_rxd_pkg;
   localparam int CLK_DIV_DEF = 208;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer with falling-edge detect on the synchronized line
module rx_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic fall
);
   logic s1, s2, prev;
   // shift the raw line through two flops, keep one more copy for edge detect
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) {s1, s2, prev} <= 3'b111;
      else {s1, s2, prev} <= {d, s1, s2};
   assign q = s2;
   assign fall = prev & ~s2;
endmodule

// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 UART receiver with ready/overrun/framing flags and break handling
module uart_rxd
   import uart_rxd_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxd,
   input  logic       rd,
   output logic [7:0] data,
   output logic       ready,
   output logic       overrun,
   output logic       ferr,
   output logic       busy
);
   localparam logic [11:0] HALF_M1 = 12'(CLK_DIV / 2 - 1);
   localparam logic [11:0] DIV_M1 = 12'(CLK_DIV - 1);
   rx_state_t state, nxt;
   logic rxs, fall, go, smp, ok, bad, armed;
   logic [1:0] warm;
   logic [11:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   rx_sync u_sync (
      .clk(clk),
      .reset_n(reset_n),
      .d(rxd),
      .q(rxs),
      .fall(fall)
   );
   assign go = fall & armed;
   assign smp = cnt == 12'd0;
   assign busy = state != IDLE;
   // a start edge only counts once the real line (not the synchronizer reset value) has been seen high
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         warm <= 2'b00;
         armed <= 1'b0;
      end else begin
         warm <= {warm[0], 1'b1};
         armed <= armed | (warm[1] & rxs);
      end
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   // next state plus good-byte / framing-error decode at the stop sample
   always_comb begin
      nxt = state;
      ok = 1'b0;
      bad = 1'b0;
      case (state)
         IDLE: nxt = go ? START : IDLE;
         START: nxt = smp ? (rxs ? IDLE : DATA) : START;
         DATA: nxt = (smp && idx == 3'd7) ? STOP : DATA;
         STOP: begin
            nxt = smp ? (rxs ? IDLE : BREAK) : STOP;
            ok = smp & rxs;
            bad = smp & ~rxs;
         end
         BREAK: nxt = rxs ? IDLE : BREAK;
         default: nxt = IDLE;
      endcase
   end
   // bit timing, data shifting and host-visible flags; a completing byte beats a simultaneous read
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt <= 12'd0;
         idx <= 3'd0;
         shift <= 8'h00;
         data <= 8'h00;
         ready <= 1'b0;
         overrun <= 1'b0;
         ferr <= 1'b0;
      end else begin
         cnt <= (state == IDLE) ? (go ? HALF_M1 : 12'd0) : (smp ? DIV_M1 : cnt - 12'd1);
         if (smp) idx <= (state == DATA) ? idx + 3'd1 : 3'd0;
         if (smp && state == DATA) shift <= {rxs, shift[7:1]};
         if (ok) data <= shift;
         ready <= ok | (ready & ~rd);
         overrun <= (overrun | (ok & ready)) & ~rd;
         ferr <= (ferr & ~rd) | bad;
      end
endmodule
